operand_writeback: RTL and testbench
====================================

// Module: operand_writeback
// PURPOSE
//  Commit stage after the execute units: takes the opnd0_w/opnd1_w pair from move/swap/ALU
//  results and writes each result to its destination, either a GPR or memory.
//  - Handles 8/16/32-bit widths, including AH..BH byte merges, and memory byte strobes.
//  - Sequences the two destination writes: dst0 first, then dst1.
// PARAMETERS
//  none; widths are fixed by the tiny86 ISA (32-bit data, 8 GPRs)
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  wb_valid     in   1   result bundle valid
//  wb_ready     out  1   1 only in IDLE; transfer on wb_valid&wb_ready
//  opnd0_w      in   32  value for destination 0
//  opnd1_w      in   32  value for destination 1
//  dst0_en      in   1   dest 0 write enabled
//  dst1_en      in   1   dest 1 write enabled (swap only)
//  dst0_is_mem  in   1   1=memory, 0=GPR
//  dst1_is_mem  in   1   1=memory, 0=GPR
//  dst0_reg     in   3   GPR index
//  dst1_reg     in   3   GPR index
//  dst0_addr    in   32  byte address
//  dst1_addr    in   32  byte address
//  opnd_size    in   2   00=8b, 01=16b, 10=32b, 11=reserved
//  rf_raddr     out  3   GPR read index (comb. read, used for partial merge)
//  rf_rdata     in   32  GPR read data
//  rf_we        out  1   GPR write enable
//  rf_waddr     out  3   GPR write index
//  rf_wdata     out  32  merged GPR write data
//  mem_req      out  1   memory write request, held until mem_ack
//  mem_addr     out  32  word address ({addr[31:2],2'b00})
//  mem_wdata    out  32  lane-shifted data
//  mem_wstrb    out  4   byte strobes
//  mem_ack      in   1   write accepted; ignored while mem_req=0
//  wb_done      out  1   1-cycle pulse, bundle fully retired
//  wb_fault     out  1   valid with wb_done; misaligned/reserved access occurred
// BEHAVIOUR
//  - Reset values: all outputs 0, except wb_ready=1. FSM returns to IDLE.
//  - FSM states: IDLE -> SLOT0 -> SLOT1 -> DONE -> IDLE.
//  - On handshake, latch all inputs into the bundle register.
//  - SLOTn, dst disabled: 1 cycle, no write.
//  - SLOTn, GPR: 1 cycle; rf_raddr/rf_we/rf_waddr/rf_wdata valid in that cycle.
//  - SLOTn, mem: mem_req=1 with addr/data/strb stable until the mem_ack cycle; advance after ack.
//  - DONE: wb_done=1, wb_fault=OR of slot faults.
//  - Latency: reg/reg bundle accepted at T gives writes at T+1 and T+2, wb_done at T+3.
//  - GPR merge:
//    - 32b: full write.
//    - 16b: {old[31:16],v[15:0]}.
//    - 8b, idx 0-3: low byte.
//    - 8b, idx 4-7: byte1 of reg idx-4 (AH,CH,DH,BH); rf_waddr=idx-4.
//  - Memory lanes:
//    - 8b: strb=1<<a[1:0].
//    - 16b: strb=0011<<a[1:0].
//    - 32b: strb=1111.
//    - Data shifted by 8*a[1:0].
//  - Faults: 16b with a[0]=1, 32b with a[1:0]!=0, or size 11 (either dest type).
//    - Faulting slot performs no write and takes 1 cycle.
//    - The other slot still executes.
//  - Same GPR in both slots: dst1 write lands last and wins (xchg r,r identity).
//  - Reset mid-operation: mem_req drops immediately, no wb_done, bundle discarded.
// CONFIGURATION
//  WB_COMMIT_COUNT_EN
//  - Defined: adds output commit_count[31:0], reset 0.
//    - Increments by 1 per non-faulting write (GPR or mem-ack).
//    - Wraps at 2^32.
//  - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared include writeback.vh:
//  - size codes WB_SZ_8/16/32/RSVD
//  - FSM state encodings
//  - AH..BH index offset
//  Sub-module wb_lane_merge (combinational), one instance per active slot:
//  - GPR merge
//  - mem strobe/shift
//  - fault detect
// TESTING
//  1 Swap: dst0=GPR0 and dst1=GPR3, 32b, opnd0_w=0x11111111, opnd1_w=0x22222222.
//    -> rf writes (0,0x11111111) then (3,0x22222222); wb_done at T+3; fault=0.
//  2 8b write: dst0=GPR4 (AH), v=0xAB, rf_rdata=0x12345678.
//    -> rf_waddr=0, rf_wdata=0x1234AB78.
//  3 Mem write: 16b, addr 0x1002, v=0xBEEF, mem_ack held off 3 cycles.
//    -> mem_addr=0x1000, strb=1100, wdata=0xBEEF0000 stable; done 1 cycle after ack.
//  4 Misaligned mem: 32b mem addr 0x1001 plus GPR dst1.
//    -> no mem_req, GPR dst1 still written; wb_done with wb_fault=1.
//  5 Reset mid-write: rst asserted while mem_req=1.
//    -> mem_req=0 same cycle, wb_ready=1, no wb_done; next bundle processes normally.
//  6 WB_COMMIT_COUNT_EN: scenario 1, then scenario 4.
//    -> commit_count=2, then 3.

Source files
------------

// File: rtl/operand_writeback_pkg.sv
// Shared definitions for the operand writeback stage: size codes, FSM states,
// the AH..BH index offset and the per-slot destination record.
package operand_writeback_pkg;

   typedef enum logic [1:0] {
      WB_SZ_8    = 2'b00,
      WB_SZ_16   = 2'b01,
      WB_SZ_32   = 2'b10,
      WB_SZ_RSVD = 2'b11
   } wb_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SLOT0,
      ST_SLOT1,
      ST_DONE
   } wb_state_e;

   // 8-bit indices 4..7 name byte 1 of GPRs 0..3 (AH, CH, DH, BH)
   localparam logic [2:0] WB_HIGH_BYTE_OFS = 3'd4;

   typedef struct packed {
      logic        en;
      logic        is_mem;
      logic [2:0]  reg_idx;
      logic [31:0] addr;
      logic [31:0] value;
   } wb_slot_t;

   function automatic logic [3:0] wb_base_strb(input wb_size_e sz);
      logic [3:0] strb;
      case (sz)
         WB_SZ_8:  strb = 4'b0001;
         WB_SZ_16: strb = 4'b0011;
         WB_SZ_32: strb = 4'b1111;
         default:  strb = 4'b0000;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/operand_writeback_lane_merge.sv
// Combinational per-slot write formatter: GPR partial merge, memory lane
// strobes/shift and fault detection for one destination.
module wb_lane_merge
   import operand_writeback_pkg::*;
(
   input  wb_slot_t    slot,
   input  wb_size_e    size,
   input  logic [31:0] rf_rdata,
   output logic        gpr_go,
   output logic        mem_go,
   output logic        fault,
   output logic [2:0]  rf_idx,
   output logic [31:0] rf_wdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb
);

   logic [1:0] lane;
   logic       misaligned;
   logic       high_byte;

   always_comb begin
      lane = slot.addr[1:0];
      case (size)
         WB_SZ_16: misaligned = slot.addr[0];
         WB_SZ_32: misaligned = |lane;
         default:  misaligned = 1'b0;
      endcase

      // Alignment only matters for memory; the reserved size faults everywhere
      fault     = slot.en & ((size == WB_SZ_RSVD) | (slot.is_mem & misaligned));
      gpr_go    = slot.en & ~slot.is_mem & ~fault;
      mem_go    = slot.en & slot.is_mem & ~fault;
      high_byte = (size == WB_SZ_8) & slot.reg_idx[2];

      rf_idx    = '0;
      rf_wdata  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;

      if (gpr_go) begin
         rf_idx = high_byte ? (slot.reg_idx - WB_HIGH_BYTE_OFS) : slot.reg_idx;
         case (size)
            WB_SZ_8:  rf_wdata = high_byte ? {rf_rdata[31:16], slot.value[7:0], rf_rdata[7:0]}
                                           : {rf_rdata[31:8], slot.value[7:0]};
            WB_SZ_16: rf_wdata = {rf_rdata[31:16], slot.value[15:0]};
            default:  rf_wdata = slot.value;
         endcase
      end

      if (mem_go) begin
         mem_addr  = {slot.addr[31:2], 2'b00};
         mem_wdata = slot.value << {lane, 3'b000};
         mem_wstrb = wb_base_strb(size) << lane;
      end
   end

endmodule

// File: rtl/operand_writeback.sv
// Commit stage: retires a two-destination result bundle, dst0 then dst1, to GPRs
// or memory. Optional WB_COMMIT_COUNT_EN adds a commit_count output.
module operand_writeback
   import operand_writeback_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [31:0] opnd0_w,
   input  logic [31:0] opnd1_w,
   input  logic        dst0_en,
   input  logic        dst1_en,
   input  logic        dst0_is_mem,
   input  logic        dst1_is_mem,
   input  logic [2:0]  dst0_reg,
   input  logic [2:0]  dst1_reg,
   input  logic [31:0] dst0_addr,
   input  logic [31:0] dst1_addr,
   input  logic [1:0]  opnd_size,
   output logic [2:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   output logic        wb_done,
   output logic        wb_fault
`ifdef WB_COMMIT_COUNT_EN
   ,
   output logic [31:0] commit_count
`endif
);

   wb_state_e state;
   wb_slot_t  slot0_q;
   wb_slot_t  slot1_q;
   wb_size_e  size_q;
   logic      fault_acc;

   logic        l0_gpr_go, l0_mem_go, l0_fault;
   logic [2:0]  l0_rf_idx;
   logic [31:0] l0_rf_wdata, l0_mem_addr, l0_mem_wdata;
   logic [3:0]  l0_mem_wstrb;
   logic        l1_gpr_go, l1_mem_go, l1_fault;
   logic [2:0]  l1_rf_idx;
   logic [31:0] l1_rf_wdata, l1_mem_addr, l1_mem_wdata;
   logic [3:0]  l1_mem_wstrb;

   logic cur_fault;
   logic slot_advance;

   wb_lane_merge u_lane0 (
      .slot      (slot0_q),
      .size      (size_q),
      .rf_rdata  (rf_rdata),
      .gpr_go    (l0_gpr_go),
      .mem_go    (l0_mem_go),
      .fault     (l0_fault),
      .rf_idx    (l0_rf_idx),
      .rf_wdata  (l0_rf_wdata),
      .mem_addr  (l0_mem_addr),
      .mem_wdata (l0_mem_wdata),
      .mem_wstrb (l0_mem_wstrb)
   );

   wb_lane_merge u_lane1 (
      .slot      (slot1_q),
      .size      (size_q),
      .rf_rdata  (rf_rdata),
      .gpr_go    (l1_gpr_go),
      .mem_go    (l1_mem_go),
      .fault     (l1_fault),
      .rf_idx    (l1_rf_idx),
      .rf_wdata  (l1_rf_wdata),
      .mem_addr  (l1_mem_addr),
      .mem_wdata (l1_mem_wdata),
      .mem_wstrb (l1_mem_wstrb)
   );

   // Write ports are decoded from the registered state so an async reset
   // removes mem_req and rf_we in the same cycle.
   always_comb begin
      rf_raddr  = '0;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      cur_fault = 1'b0;
      case (state)
         ST_SLOT0: begin
            rf_raddr  = l0_rf_idx;
            rf_we     = l0_gpr_go;
            rf_waddr  = l0_rf_idx;
            rf_wdata  = l0_rf_wdata;
            mem_req   = l0_mem_go;
            mem_addr  = l0_mem_addr;
            mem_wdata = l0_mem_wdata;
            mem_wstrb = l0_mem_wstrb;
            cur_fault = l0_fault;
         end
         ST_SLOT1: begin
            rf_raddr  = l1_rf_idx;
            rf_we     = l1_gpr_go;
            rf_waddr  = l1_rf_idx;
            rf_wdata  = l1_rf_wdata;
            mem_req   = l1_mem_go;
            mem_addr  = l1_mem_addr;
            mem_wdata = l1_mem_wdata;
            mem_wstrb = l1_mem_wstrb;
            cur_fault = l1_fault;
         end
         default: ;
      endcase
   end

   assign slot_advance = ~mem_req | mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         wb_ready  <= 1'b1;
         wb_done   <= 1'b0;
         wb_fault  <= 1'b0;
         fault_acc <= 1'b0;
         slot0_q   <= '0;
         slot1_q   <= '0;
         size_q    <= WB_SZ_8;
      end else begin
         wb_done  <= 1'b0;
         wb_fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (wb_valid) begin
                  slot0_q   <= '{en: dst0_en, is_mem: dst0_is_mem, reg_idx: dst0_reg,
                                 addr: dst0_addr, value: opnd0_w};
                  slot1_q   <= '{en: dst1_en, is_mem: dst1_is_mem, reg_idx: dst1_reg,
                                 addr: dst1_addr, value: opnd1_w};
                  size_q    <= wb_size_e'(opnd_size);
                  fault_acc <= 1'b0;
                  wb_ready  <= 1'b0;
                  state     <= ST_SLOT0;
               end
            end
            ST_SLOT0: begin
               if (slot_advance) begin
                  fault_acc <= cur_fault;
                  state     <= ST_SLOT1;
               end
            end
            ST_SLOT1: begin
               if (slot_advance) begin
                  wb_done  <= 1'b1;
                  wb_fault <= fault_acc | cur_fault;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               wb_ready <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef WB_COMMIT_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         commit_count <= '0;
      else if (rf_we | (mem_req & mem_ack))
         commit_count <= commit_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_operand_writeback.sv
// Randomised self-checking bench for operand_writeback with a byte-level
// reference model of GPR merges, memory lanes, faults and slot sequencing.
module tb_operand_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] opnd0_w, opnd1_w;
   logic        dst0_en, dst1_en, dst0_is_mem, dst1_is_mem;
   logic [2:0]  dst0_reg, dst1_reg;
   logic [31:0] dst0_addr, dst1_addr;
   logic [1:0]  opnd_size;
   logic [2:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        mem_req;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic        wb_done, wb_fault;
`ifdef WB_COMMIT_COUNT_EN
   logic [31:0] commit_count;
`endif

   logic [31:0] rf_model [8];
   assign rf_rdata = rf_model[rf_raddr];

   int checks = 0;
   int errors = 0;
   int unsigned model_count = 0;
   logic        pend_we = 1'b0;
   logic [2:0]  pend_idx;
   logic [31:0] pend_val;

   always #5 clk = ~clk;

   operand_writeback dut (
      .clk          (clk),
      .rst          (rst),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .opnd0_w      (opnd0_w),
      .opnd1_w      (opnd1_w),
      .dst0_en      (dst0_en),
      .dst1_en      (dst1_en),
      .dst0_is_mem  (dst0_is_mem),
      .dst1_is_mem  (dst1_is_mem),
      .dst0_reg     (dst0_reg),
      .dst1_reg     (dst1_reg),
      .dst0_addr    (dst0_addr),
      .dst1_addr    (dst1_addr),
      .opnd_size    (opnd_size),
      .rf_raddr     (rf_raddr),
      .rf_rdata     (rf_rdata),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_ack      (mem_ack),
      .wb_done      (wb_done),
      .wb_fault     (wb_fault)
`ifdef WB_COMMIT_COUNT_EN
      ,
      .commit_count (commit_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // The model register file commits at the clock edge, like a real RF
   task automatic tick();
      @(posedge clk);
      if (pend_we) begin
         rf_model[pend_idx] = pend_val;
         pend_we = 1'b0;
      end
      #1;
   endtask

   // kind: 0 = no write, 1 = GPR write, 2 = memory write
   task automatic slot_model(input bit en, input bit is_mem, input logic [2:0] ridx,
                             input logic [31:0] addr, input logic [31:0] v, input logic [1:0] sz,
                             output int kind, output bit flt, output logic [2:0] widx,
                             output logic [31:0] wdata, output logic [31:0] maddr,
                             output logic [3:0] strb);
      int nbytes, pos, off;
      kind = 0; flt = 1'b0; widx = '0; wdata = '0; maddr = '0; strb = '0;
      if (!en) return;
      nbytes = 1 << sz;
      off    = int'(addr[1:0]);
      if (sz == 2'd3 || (is_mem && (off % nbytes) != 0)) begin
         flt = 1'b1;
         return;
      end
      if (!is_mem) begin
         kind = 1;
         pos  = 0;
         widx = ridx;
         if (sz == 2'd0 && ridx >= 3'd4) begin
            pos  = 1;
            widx = ridx - 3'd4;
         end
         wdata = rf_model[widx];
         for (int b = 0; b < nbytes; b++) wdata[8*(pos+b) +: 8] = v[8*b +: 8];
      end else begin
         kind  = 2;
         maddr = addr & 32'hFFFF_FFFC;
         strb  = 4'(((1 << nbytes) - 1) << off);
         wdata = v << (8 * off);
      end
   endtask

   task automatic drive_bundle(input logic [31:0] v0, input logic [31:0] v1,
                               input bit e0, input bit e1, input bit m0, input bit m1,
                               input logic [2:0] r0, input logic [2:0] r1,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] sz);
      opnd0_w = v0; opnd1_w = v1; dst0_en = e0; dst1_en = e1;
      dst0_is_mem = m0; dst1_is_mem = m1; dst0_reg = r0; dst1_reg = r1;
      dst0_addr = a0; dst1_addr = a1; opnd_size = sz; wb_valid = 1'b1;
   endtask

   task automatic scramble_inputs();
      opnd0_w = $urandom; opnd1_w = $urandom; dst0_addr = $urandom; dst1_addr = $urandom;
      dst0_en = 1'($urandom); dst1_en = 1'($urandom);
      dst0_is_mem = 1'($urandom); dst1_is_mem = 1'($urandom);
      dst0_reg = 3'($urandom); dst1_reg = 3'($urandom); opnd_size = 2'($urandom);
   endtask

   task automatic run_bundle(input logic [31:0] v0, input logic [31:0] v1,
                             input bit e0, input bit e1, input bit m0, input bit m1,
                             input logic [2:0] r0, input logic [2:0] r1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [1:0] sz, input int d0, input int d1);
      int kind, d;
      bit flt, any_flt;
      logic [2:0]  widx;
      logic [31:0] wdata, maddr;
      logic [3:0]  strb;
      check("ready_idle", wb_ready, 1);
      drive_bundle(v0, v1, e0, e1, m0, m1, r0, r1, a0, a1, sz);
      tick();
      wb_valid = 1'b0;
      scramble_inputs();
      any_flt = 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (s == 0) slot_model(e0, m0, r0, a0, v0, sz, kind, flt, widx, wdata, maddr, strb);
         else        slot_model(e1, m1, r1, a1, v1, sz, kind, flt, widx, wdata, maddr, strb);
         d = (s == 0) ? d0 : d1;
         any_flt |= flt;
         check("ready_busy", wb_ready, 0);
         check("done_early", wb_done, 0);
         if (kind == 1) begin
            mem_ack = 1'($urandom);
            check("rf_we", rf_we, 1);
            check("rf_raddr", rf_raddr, widx);
            check("rf_waddr", rf_waddr, widx);
            check("rf_wdata", rf_wdata, wdata);
            check("mem_req_gpr", mem_req, 0);
            pend_we = 1'b1; pend_idx = widx; pend_val = wdata;
            model_count++;
            tick();
         end else if (kind == 2) begin
            for (int c = 0; c <= d; c++) begin
               mem_ack = (c == d);
               check("mem_req", mem_req, 1);
               check("mem_addr", mem_addr, maddr);
               check("mem_wdata", mem_wdata, wdata);
               check("mem_wstrb", mem_wstrb, strb);
               check("rf_we_mem", rf_we, 0);
               tick();
            end
            mem_ack = 1'b0;
            model_count++;
         end else begin
            mem_ack = 1'($urandom);
            check("rf_we_idle_slot", rf_we, 0);
            check("mem_req_idle_slot", mem_req, 0);
            tick();
         end
      end
      mem_ack = 1'b0;
      check("wb_done", wb_done, 1);
      check("wb_fault", wb_fault, any_flt);
      tick();
      check("done_pulse", wb_done, 0);
      check("ready_back", wb_ready, 1);
`ifdef WB_COMMIT_COUNT_EN
      check("commit_count", commit_count, model_count);
`endif
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; mem_ack = 1'b0;
      drive_bundle('0, '0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
      wb_valid = 1'b0;
      for (int i = 0; i < 8; i++) rf_model[i] = $urandom;
      tick(); tick();
      check("rst_ready", wb_ready, 1);
      check("rst_done", wb_done, 0);
      check("rst_fault", wb_fault, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_wstrb", mem_wstrb, 0);
`ifdef WB_COMMIT_COUNT_EN
      check("rst_commit_count", commit_count, 0);
`endif
      rst = 1'b0;
      tick();

      // Swap to GPR0/GPR3, then misaligned 32-bit store with a GPR second dest
      run_bundle(32'h1111_1111, 32'h2222_2222, 1, 1, 0, 0, 3'd0, 3'd3, '0, '0, 2'b10, 0, 0);
      check("swap_r0", rf_model[0], 32'h1111_1111);
      check("swap_r3", rf_model[3], 32'h2222_2222);
`ifdef WB_COMMIT_COUNT_EN
      check("cc_after_swap", commit_count, 2);
`endif
      run_bundle('0, 32'hCAFE_F00D, 1, 1, 1, 0, 3'd0, 3'd5, 32'h1001, '0, 2'b10, 0, 0);
      check("misaligned_r5", rf_model[5], 32'hCAFE_F00D);
`ifdef WB_COMMIT_COUNT_EN
      check("cc_after_fault", commit_count, 3);
`endif

      // AH write into 0x12345678
      rf_model[0] = 32'h1234_5678;
      run_bundle(32'h0000_00AB, '0, 1, 0, 0, 0, 3'd4, '0, '0, '0, 2'b00, 0, 0);
      check("ah_merge", rf_model[0], 32'h1234_AB78);

      // 16-bit store to 0x1002 with acknowledge held off three cycles
      run_bundle('0, 32'h0000_BEEF, 0, 1, 0, 1, '0, '0, '0, 32'h1002, 2'b01, 0, 3);

      // Reset while a store is waiting for its acknowledge
      drive_bundle(32'hDEAD_BEEF, '0, 1, 0, 1, 0, '0, '0, 32'h2000, '0, 2'b10);
      tick();
      wb_valid = 1'b0;
      tick();
      check("pre_rst_mem_req", mem_req, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_mem_req", mem_req, 0);
      check("rst_mid_ready", wb_ready, 1);
      check("rst_mid_done", wb_done, 0);
      model_count = 0;
      tick();
      check("rst_hold_done", wb_done, 0);
      rst = 1'b0;
      tick();
      check("post_rst_done", wb_done, 0);
      run_bundle(32'h0000_5A5A, 32'h7777_0001, 1, 1, 0, 0, 3'd2, 3'd2, '0, '0, 2'b01, 0, 0);

      for (int n = 0; n < 60; n++) begin
         run_bundle($urandom, $urandom, 1'($urandom_range(0, 4) != 0), 1'($urandom),
                    1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                    {24'h0000_10, 8'($urandom)}, {24'h0000_20, 8'($urandom)},
                    2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
